// File: rtl/clk_freq_monitor_pkg.sv
// Shared types and constants for the clock frequency monitor.
// BUS_CLK rate and the monitor FSM encoding.
package clk_freq_monitor_pkg;

  localparam int BUS_CLK_HZ = 48_000_000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clk_freq_monitor_sync.sv
// Two-flop synchroniser with an extra flop for edge detection.
// level is the synchronised value; rise/fall are single-cycle pulses.
module cdc_sync_edge (
  input  logic BUS_CLK,
  input  logic BUS_RST,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/clk_freq_monitor.sv
// Gated edge counter on a prescaled toggle plus DCM lock-loss tracking.
// Windows run back to back while lock holds; a lock drop aborts them.
module clk_freq_monitor
  import clk_freq_monitor_pkg::*;
#(
  parameter int GATE_CYCLES   = BUS_CLK_HZ / 1000,
  parameter int SETTLE_CYCLES = 4800,
  parameter int CNT_W         = 16,
  parameter int EXP_MIN       = 990,
  parameter int EXP_MAX       = 1010
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST,
  input  logic             MON_TOGGLE,
  input  logic             LOCKED,
  input  logic             CLEAR,
  output logic [CNT_W-1:0] FREQ_COUNT,
  output logic             FREQ_VALID,
  output logic             FREQ_OK,
  output logic             MEASURING,
  output logic             LOCK_LOST,
  output logic [7:0]       LOSS_CNT
);

  localparam int GATE_W = $clog2(GATE_CYCLES + 1);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LAST =
    GATE_W'(GATE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYCLES - 1);
  localparam logic [31:0] MIN_W = 32'(EXP_MIN);
  localparam logic [31:0] MAX_W = 32'(EXP_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [CNT_W-1:0]  win_cnt;
  logic [31:0]       win_w;
  logic              win_ok;

  logic mon_level;
  logic mon_rise;
  logic mon_fall;
  logic lock_s;
  logic lock_rise;
  logic lock_fall;
  logic mon_edge;
  logic unused_sync;

  cdc_sync_edge u_mon_sync (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .d       (MON_TOGGLE),
    .level   (mon_level),
    .rise    (mon_rise),
    .fall    (mon_fall)
  );

  cdc_sync_edge u_lock_sync (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .d       (LOCKED),
    .level   (lock_s),
    .rise    (lock_rise),
    .fall    (lock_fall)
  );

  assign unused_sync = mon_level ^ lock_rise;
  assign mon_edge    = mon_rise | mon_fall;

  // Count including an edge on this cycle, saturating at all-ones.
  assign win_cnt = (mon_edge && edge_cnt != CNT_MAX)
                 ? edge_cnt + CNT_W'(1) : edge_cnt;
  assign win_w   = 32'(win_cnt);
  assign win_ok  = (win_cnt != CNT_MAX) &&
                   (win_w >= MIN_W) && (win_w <= MAX_W);

  assign MEASURING = (state == MEASURE);

  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state      <= IDLE;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      edge_cnt   <= '0;
      FREQ_COUNT <= '0;
      FREQ_VALID <= 1'b0;
      FREQ_OK    <= 1'b0;
      LOCK_LOST  <= 1'b0;
      LOSS_CNT   <= '0;
    end else begin
      FREQ_VALID <= 1'b0;

      // A loss on the same cycle as CLEAR restarts the tally at one.
      if (lock_fall) begin
        LOCK_LOST <= 1'b1;
        LOSS_CNT  <= CLEAR ? 8'd1 : sat_inc8(LOSS_CNT);
      end else if (CLEAR) begin
        LOCK_LOST <= 1'b0;
        LOSS_CNT  <= '0;
      end

      if (!lock_s) begin
        state      <= IDLE;
        gate_cnt   <= '0;
        settle_cnt <= '0;
        edge_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
          SETTLE: begin
            if (settle_cnt == SET_LAST) begin
              state    <= MEASURE;
              gate_cnt <= '0;
              edge_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + SET_W'(1);
            end
          end
          MEASURE: begin
            if (gate_cnt == GATE_LAST) begin
              FREQ_COUNT <= win_cnt;
              FREQ_OK    <= win_ok;
              FREQ_VALID <= 1'b1;
              gate_cnt   <= '0;
              edge_cnt   <= '0;
            end else begin
              gate_cnt <= gate_cnt + GATE_W'(1);
              edge_cnt <= win_cnt;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Bench for clk_freq_monitor: nominal, off-frequency, lock loss,
// CLEAR collision, counter saturation and asynchronous reset.
module tb_clk_freq_monitor;

  logic        BUS_CLK;
  logic        BUS_RST;
  logic        MON_TOGGLE;
  logic        LOCKED;
  logic        CLEAR;
  logic [15:0] FREQ_COUNT;
  logic        FREQ_VALID;
  logic        FREQ_OK;
  logic        MEASURING;
  logic        LOCK_LOST;
  logic [7:0]  LOSS_CNT;

  logic [4:0]  b_count;
  logic        b_valid;
  logic        b_ok;
  logic        b_meas;
  logic        b_lost;
  logic [7:0]  b_loss;

  typedef struct packed {
    logic [15:0] cnt;
    logic        ok;
  } exp_t;

  exp_t        exp_a[$];
  logic [4:0]  exp_b[$];

  int n_chk  = 0;
  int n_fail = 0;
  int half   = 0;
  int tcnt   = 0;

  clk_freq_monitor #(
    .GATE_CYCLES   (480),
    .SETTLE_CYCLES (20),
    .CNT_W         (16),
    .EXP_MIN       (46),
    .EXP_MAX       (50)
  ) dut (
    .BUS_CLK    (BUS_CLK),
    .BUS_RST    (BUS_RST),
    .MON_TOGGLE (MON_TOGGLE),
    .LOCKED     (LOCKED),
    .CLEAR      (CLEAR),
    .FREQ_COUNT (FREQ_COUNT),
    .FREQ_VALID (FREQ_VALID),
    .FREQ_OK    (FREQ_OK),
    .MEASURING  (MEASURING),
    .LOCK_LOST  (LOCK_LOST),
    .LOSS_CNT   (LOSS_CNT)
  );

  clk_freq_monitor #(
    .GATE_CYCLES   (480),
    .SETTLE_CYCLES (20),
    .CNT_W         (5),
    .EXP_MIN       (46),
    .EXP_MAX       (50)
  ) dut_sat (
    .BUS_CLK    (BUS_CLK),
    .BUS_RST    (BUS_RST),
    .MON_TOGGLE (MON_TOGGLE),
    .LOCKED     (LOCKED),
    .CLEAR      (CLEAR),
    .FREQ_COUNT (b_count),
    .FREQ_VALID (b_valid),
    .FREQ_OK    (b_ok),
    .MEASURING  (b_meas),
    .LOCK_LOST  (b_lost),
    .LOSS_CNT   (b_loss)
  );

  initial begin
    BUS_CLK = 1'b0;
    forever #5 BUS_CLK = ~BUS_CLK;
  end

  // Toggle source: flips every 'half' BUS_CLK cycles, 0 = stopped.
  initial begin
    MON_TOGGLE = 1'b0;
    forever begin
      @(negedge BUS_CLK);
      if (half != 0) begin
        if (tcnt >= half - 1) begin
          MON_TOGGLE = ~MON_TOGGLE;
          tcnt = 0;
        end else begin
          tcnt++;
        end
      end
    end
  end

  task automatic wait_valid(input int budget, output bit got,
                            output int cycles);
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge BUS_CLK);
      cycles = i + 1;
      if (FREQ_VALID) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge BUS_CLK);
  endtask

  task automatic pop_check(input string name);
    bit   got;
    int   cyc;
    exp_t e;
    wait_valid(600, got, cyc);
    e = exp_a.pop_front();
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s_valid: got none in %0d cycles", name, cyc);
    end else begin
      if (FREQ_COUNT !== e.cnt) begin
        n_fail++;
        $display("FAIL %s_count: got %0d expected %0d",
                 name, FREQ_COUNT, e.cnt);
      end
      n_chk++;
      if (FREQ_OK !== e.ok) begin
        n_fail++;
        $display("FAIL %s_ok: got %0b expected %0b",
                 name, FREQ_OK, e.ok);
      end
    end
  endtask

  task automatic flush_window();
    bit got;
    int cyc;
    wait_valid(1200, got, cyc);
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL flush_valid: got none in %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    BUS_RST = 1'b1;
    LOCKED  = 1'b0;
    CLEAR   = 1'b0;
    half    = 0;
    wait_cycles(4);
    BUS_RST = 1'b0;
    wait_cycles(2);
    n_chk++;
    if ({FREQ_COUNT, FREQ_VALID, FREQ_OK, MEASURING,
         LOCK_LOST, LOSS_CNT} !== 29'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {FREQ_COUNT, FREQ_VALID, FREQ_OK, MEASURING,
                LOCK_LOST, LOSS_CNT});
    end
  endtask

  task automatic test_nominal();
    bit got;
    int cyc;
    half = 10;
    tcnt = 0;
    LOCKED = 1'b1;
    wait_valid(600, got, cyc);
    n_chk++;
    if (!got || cyc < 500 || cyc > 506) begin
      n_fail++;
      $display("FAIL first_latency: got %0d expected 503", cyc);
    end
    exp_a.push_back('{cnt: 16'd48, ok: 1'b1});
    pop_check("nominal_w2");
    exp_a.push_back('{cnt: 16'd48, ok: 1'b1});
    pop_check("nominal_w3");
  endtask

  task automatic test_off_freq();
    half = 8;
    flush_window();
    exp_a.push_back('{cnt: 16'd60, ok: 1'b0});
    pop_check("off_freq");
  endtask

  task automatic test_stopped();
    half = 0;
    flush_window();
    exp_a.push_back('{cnt: 16'd0, ok: 1'b0});
    pop_check("stopped");
  endtask

  task automatic test_lock_drop();
    bit seen;
    half = 10;
    flush_window();
    exp_a.push_back('{cnt: 16'd48, ok: 1'b1});
    pop_check("pre_drop");
    wait_cycles(200);
    LOCKED = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge BUS_CLK);
      if (FREQ_VALID) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL drop_no_valid: got pulse expected none");
    end
    n_chk++;
    if (LOCK_LOST !== 1'b1 || LOSS_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_flags: got %0b/%0d expected 1/1",
               LOCK_LOST, LOSS_CNT);
    end
    n_chk++;
    if (MEASURING !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: got %0b expected 0", MEASURING);
    end
    n_chk++;
    if (FREQ_COUNT !== 16'd48 || FREQ_OK !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_held: got %0d/%0b expected 48/1",
               FREQ_COUNT, FREQ_OK);
    end
  endtask

  task automatic test_relock();
    bit ok;
    LOCKED = 1'b1;
    wait_cycles(10);
    n_chk++;
    if (MEASURING !== 1'b0) begin
      n_fail++;
      $display("FAIL relock_settle: got %0b expected 0", MEASURING);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge BUS_CLK);
      if (MEASURING) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL relock_measure: got 0 expected 1");
    end
    exp_a.push_back('{cnt: 16'd48, ok: 1'b1});
    pop_check("relock");
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 4; i++) begin
      LOCKED = 1'b0;
      wait_cycles(5);
      LOCKED = 1'b1;
      wait_cycles(5);
    end
    n_chk++;
    if (LOSS_CNT !== 8'd5) begin
      n_fail++;
      $display("FAIL loss_count: got %0d expected 5", LOSS_CNT);
    end
    LOCKED = 1'b0;
    @(negedge BUS_CLK);
    @(negedge BUS_CLK);
    CLEAR = 1'b1;
    @(negedge BUS_CLK);
    CLEAR = 1'b0;
    n_chk++;
    if (LOCK_LOST !== 1'b1 || LOSS_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL collision: got %0b/%0d expected 1/1",
               LOCK_LOST, LOSS_CNT);
    end
    wait_cycles(3);
    CLEAR = 1'b1;
    @(negedge BUS_CLK);
    CLEAR = 1'b0;
    n_chk++;
    if (LOCK_LOST !== 1'b0 || LOSS_CNT !== 8'd0) begin
      n_fail++;
      $display("FAIL clear_alone: got %0b/%0d expected 0/0",
               LOCK_LOST, LOSS_CNT);
    end
  endtask

  task automatic test_saturation();
    LOCKED = 1'b1;
    half = 4;
    flush_window();
    exp_b.push_back(5'd31);
    exp_a.push_back('{cnt: 16'd120, ok: 1'b0});
    pop_check("fast_wide");
    n_chk++;
    if (b_count !== exp_b[0] || b_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL saturate: got %0d/%0b expected %0d/0",
               b_count, b_ok, exp_b[0]);
    end
    void'(exp_b.pop_front());
  endtask

  task automatic test_async_reset();
    wait_cycles(100);
    #2;
    BUS_RST = 1'b1;
    #1;
    n_chk++;
    if (FREQ_COUNT !== 16'd0 || FREQ_OK !== 1'b0 ||
        MEASURING !== 1'b0 || FREQ_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %0d/%0b/%0b expected 0/0/0",
               FREQ_COUNT, FREQ_OK, MEASURING);
    end
    n_chk++;
    if (b_count !== 5'd0 || b_meas !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_sat: got %0d/%0b expected 0/0",
               b_count, b_meas);
    end
    @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    wait_cycles(2);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_off_freq();
    test_stopped();
    test_lock_drop();
    test_relock();
    test_clear_collision();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
